acknak_tracker: RTL and testbench

- Sequence-number and ACK/NAK bookkeeping stage that sits directly upstream of the replay-buffer FSM.
- Tracks NEXT_TRANSMIT_SEQ and ACKD_SEQ, and validates incoming ACK/NAK DLLPs against the outstanding window.
- Drives the FSM's acknak_i, num_to_rep and to_i inputs.
- Owns the replay timer and the REPLAY_NUM rollover counter.

---
 rtl/acknak_pkg.sv | 30 +++
 rtl/acknak_tracker_replay_timer.sv | 37 +++
 rtl/acknak_tracker.sv | 172 +++++++++++++++++
 tb/tb_acknak_tracker.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/acknak_pkg.sv
// ============================================================================
// acknak_pkg : shared encodings, state type and helpers for the ACK/NAK tracker
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package acknak_pkg;

   localparam int SEQ_W = 12;

   localparam logic [1:0] ACKNAK_NONE = 2'b00;
   localparam logic [1:0] ACKNAK_ACK  = 2'b01;
   localparam logic [1:0] ACKNAK_NAK  = 2'b10;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   // Replay word count minus one, truncated to the 12-bit num_to_rep field.
   function automatic logic [11:0] replay_words(input logic [31:0] n_tlp,
                                                input int          wpt);
      logic [31:0] w_prod;
      w_prod = n_tlp * $unsigned(wpt) - 32'd1;
      return w_prod[11:0];
   endfunction

endpackage

`default_nettype wire

// File: rtl/acknak_tracker_replay_timer.sv
// ============================================================================
// acknak_tracker_replay_timer : idle-cycle counter with clear, enable and expiry
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module acknak_tracker_replay_timer #(
   parameter int REPLAY_TIMER = 1000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expire
);

   localparam int            CW     = (REPLAY_TIMER > 1) ? $clog2(REPLAY_TIMER) : 1;
   localparam logic [CW-1:0] C_LAST = CW'(REPLAY_TIMER - 1);

   logic [CW-1:0] r_cnt;

   assign o_expire = i_en && !i_clr && (r_cnt == C_LAST);

   // Wraps back to zero on expiry so a suppressed timeout re-arms a full period.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= o_expire ? '0 : r_cnt + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/acknak_tracker.sv
// ============================================================================
// acknak_tracker : sequence-number, ACK/NAK window and replay-timer bookkeeping
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module acknak_tracker #(
   parameter int SEQ_W         = 12,
   parameter int WORDS_PER_TLP = 10,
   parameter int MAX_OUT       = 2048,
   parameter int REPLAY_TIMER  = 1000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tlp_sent,
   input  logic             dllp_valid,
   input  logic             dllp_nak,
   input  logic [SEQ_W-1:0] dllp_seq,
   input  logic             replay_done,
   output logic [SEQ_W-1:0] next_seq,
   output logic [SEQ_W-1:0] ackd_seq,
   output logic [1:0]       acknak_o,
   output logic [11:0]      num_to_rep,
   output logic             to_o,
   output logic             seq_full,
   output logic             replay_busy,
   output logic             rollover_o,
   output logic             dllp_err
);

   import acknak_pkg::*;

   state_t           r_state,  w_state_nx;
   logic [SEQ_W-1:0] r_next_seq, w_next_seq_nx;
   logic [SEQ_W-1:0] r_ackd_seq, w_ackd_seq_nx;
   logic [SEQ_W-1:0] r_outstanding, w_outstanding_nx;
   logic [1:0]       r_acknak, w_acknak_nx;
   logic [11:0]      r_num_to_rep, w_num_to_rep_nx;
   logic             r_to, w_to_nx;
   logic             r_rollover, w_rollover_nx;
   logic             r_err, w_err_nx;
   logic [1:0]       r_replay_num, w_replay_num_nx;

   logic             w_full;
   logic             w_tlp_acc;
   logic [SEQ_W-1:0] w_out_tlp;
   logic [SEQ_W-1:0] w_d;
   logic [SEQ_W-1:0] w_rem;
   logic             w_in_win;
   logic             w_ack;
   logic             w_nak_live;
   logic             w_ack_fwd;
   logic             w_nak_ok;
   logic             w_dllp_hit;
   logic             w_expire;
   logic             w_timeout;
   logic             w_tmr_clr;
   logic             w_tmr_en;
   logic [1:0]       w_rnum_base;

   assign w_full = ({1'b0, r_outstanding} == (SEQ_W + 1)'(MAX_OUT));

   // A TLP sent in the same cycle as a DLLP is counted before the window check.
   assign w_tlp_acc  = tlp_sent && !w_full && (r_state == IDLE);
   assign w_out_tlp  = r_outstanding + SEQ_W'(w_tlp_acc);
   assign w_d        = dllp_seq - r_ackd_seq;
   assign w_rem      = w_out_tlp - w_d;
   assign w_in_win   = (w_d <= w_out_tlp);
   assign w_ack      = dllp_valid && !dllp_nak;
   assign w_nak_live = dllp_valid && dllp_nak && (r_state == IDLE);
   assign w_ack_fwd  = w_ack && w_in_win && (w_d != '0);
   assign w_nak_ok   = w_nak_live && w_in_win;
   assign w_dllp_hit = (w_ack || w_nak_live) && w_in_win;
   assign w_timeout  = w_expire && !w_dllp_hit;

   assign w_tmr_en   = (r_state == IDLE) && (r_outstanding != '0);
   assign w_tmr_clr  = w_ack_fwd || w_nak_ok || (r_state != IDLE) || (r_outstanding == '0);

   acknak_tracker_replay_timer #(
      .REPLAY_TIMER (REPLAY_TIMER)
   ) u_replay_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_clr    (w_tmr_clr),
      .i_en     (w_tmr_en),
      .o_expire (w_expire)
   );

   always_comb begin
      w_state_nx       = r_state;
      w_next_seq_nx    = r_next_seq + SEQ_W'(w_tlp_acc);
      w_ackd_seq_nx    = r_ackd_seq;
      w_outstanding_nx = w_out_tlp;
      w_acknak_nx      = ACKNAK_NONE;
      w_num_to_rep_nx  = r_num_to_rep;
      w_to_nx          = 1'b0;
      w_rollover_nx    = 1'b0;
      w_err_nx         = (w_ack || w_nak_live) && !w_in_win;
      w_replay_num_nx  = r_replay_num;
      // Forward progress on a NAK resets REPLAY_NUM before the replay entry counts.
      w_rnum_base      = (w_d != '0) ? 2'd0 : r_replay_num;

      if ((r_state == REPLAY) && replay_done) begin
         w_state_nx = IDLE;
      end

      if (w_ack_fwd) begin
         w_ackd_seq_nx    = dllp_seq;
         w_outstanding_nx = w_rem;
         w_acknak_nx      = ACKNAK_ACK;
         w_replay_num_nx  = 2'd0;
      end else if (w_nak_ok) begin
         w_ackd_seq_nx    = dllp_seq;
         w_outstanding_nx = w_rem;
         w_acknak_nx      = ACKNAK_NAK;
         w_replay_num_nx  = w_rnum_base;
         if (w_rem == '0) begin
            w_num_to_rep_nx = 12'd0;
         end else begin
            w_num_to_rep_nx = replay_words(32'(w_rem), WORDS_PER_TLP);
            w_state_nx      = REPLAY;
            w_replay_num_nx = w_rnum_base + 2'd1;
            w_rollover_nx   = (w_rnum_base == 2'd3);
         end
      end else if (w_timeout) begin
         w_to_nx         = 1'b1;
         w_num_to_rep_nx = replay_words(32'(w_out_tlp), WORDS_PER_TLP);
         w_state_nx      = REPLAY;
         w_replay_num_nx = r_replay_num + 2'd1;
         w_rollover_nx   = (r_replay_num == 2'd3);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= IDLE;
         r_next_seq    <= '0;
         r_ackd_seq    <= '1;
         r_outstanding <= '0;
         r_acknak      <= ACKNAK_NONE;
         r_num_to_rep  <= '0;
         r_to          <= 1'b0;
         r_rollover    <= 1'b0;
         r_err         <= 1'b0;
         r_replay_num  <= '0;
      end else begin
         r_state       <= w_state_nx;
         r_next_seq    <= w_next_seq_nx;
         r_ackd_seq    <= w_ackd_seq_nx;
         r_outstanding <= w_outstanding_nx;
         r_acknak      <= w_acknak_nx;
         r_num_to_rep  <= w_num_to_rep_nx;
         r_to          <= w_to_nx;
         r_rollover    <= w_rollover_nx;
         r_err         <= w_err_nx;
         r_replay_num  <= w_replay_num_nx;
      end
   end

   assign next_seq    = r_next_seq;
   assign ackd_seq    = r_ackd_seq;
   assign acknak_o    = r_acknak;
   assign num_to_rep  = r_num_to_rep;
   assign to_o        = r_to;
   assign seq_full    = w_full;
   assign replay_busy = (r_state == REPLAY);
   assign rollover_o  = r_rollover;
   assign dllp_err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_acknak_tracker.sv
// ============================================================================
// tb_acknak_tracker : directed self-checking bench for acknak_tracker
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_acknak_tracker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tlp_sent;
   logic        dllp_valid;
   logic        dllp_nak;
   logic [11:0] dllp_seq;
   logic        replay_done;
   logic [11:0] next_seq;
   logic [11:0] ackd_seq;
   logic [1:0]  acknak_o;
   logic [11:0] num_to_rep;
   logic        to_o;
   logic        seq_full;
   logic        replay_busy;
   logic        rollover_o;
   logic        dllp_err;

   int n_err = 0;
   int n_chk = 0;

   acknak_tracker #(
      .SEQ_W         (12),
      .WORDS_PER_TLP (10),
      .MAX_OUT       (2048),
      .REPLAY_TIMER  (1000)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .tlp_sent    (tlp_sent),
      .dllp_valid  (dllp_valid),
      .dllp_nak    (dllp_nak),
      .dllp_seq    (dllp_seq),
      .replay_done (replay_done),
      .next_seq    (next_seq),
      .ackd_seq    (ackd_seq),
      .acknak_o    (acknak_o),
      .num_to_rep  (num_to_rep),
      .to_o        (to_o),
      .seq_full    (seq_full),
      .replay_busy (replay_busy),
      .rollover_o  (rollover_o),
      .dllp_err    (dllp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) step();
      reset_n = 1'b1;
      step();
   endtask

   task automatic send_tlps(input int n);
      for (int i = 0; i < n; i++) begin
         tlp_sent = 1'b1;
         step();
         tlp_sent = 1'b0;
      end
   endtask

   task automatic send_dllp(input logic nak, input logic [11:0] seq);
      dllp_valid = 1'b1;
      dllp_nak   = nak;
      dllp_seq   = seq;
      step();
      dllp_valid = 1'b0;
      dllp_nak   = 1'b0;
   endtask

   task automatic pulse_replay_done();
      replay_done = 1'b1;
      step();
      replay_done = 1'b0;
   endtask

   task automatic wait_timeout(output logic seen);
      seen = 1'b0;
      for (int i = 0; i < 1100 && !seen; i++) begin
         step();
         if (to_o) seen = 1'b1;
      end
   endtask

   initial begin
      logic seen;
      int   seq;

      reset_n     = 1'b0;
      tlp_sent    = 1'b0;
      dllp_valid  = 1'b0;
      dllp_nak    = 1'b0;
      dllp_seq    = '0;
      replay_done = 1'b0;
      repeat (2) step();
      check("rst_next_seq", next_seq, 0);
      check("rst_ackd_seq", ackd_seq, 12'hFFF);
      check("rst_acknak", acknak_o, 0);
      check("rst_num_to_rep", num_to_rep, 0);
      check("rst_pulses", {to_o, rollover_o, dllp_err}, 0);
      check("rst_full_busy", {seq_full, replay_busy}, 0);
      reset_n = 1'b1;
      step();

      send_tlps(4);
      check("tlp4_next_seq", next_seq, 4);
      check("tlp4_ackd_seq", ackd_seq, 4095);
      check("tlp4_acknak", acknak_o, 0);

      send_dllp(1'b0, 12'd1);
      check("ack1_acknak", acknak_o, 2'b01);
      check("ack1_ackd_seq", ackd_seq, 1);
      step();
      check("ack1_pulse_end", acknak_o, 0);
      send_dllp(1'b0, 12'd1);
      check("dup_ack_acknak", acknak_o, 0);
      check("dup_ack_ackd", ackd_seq, 1);
      check("dup_ack_err", dllp_err, 0);

      do_reset();
      send_tlps(4);
      send_dllp(1'b1, 12'd4095);
      check("nak_acknak", acknak_o, 2'b10);
      check("nak_num_to_rep", num_to_rep, 39);
      check("nak_busy", replay_busy, 1);
      check("nak_rollover", rollover_o, 0);
      send_tlps(1);
      check("replay_tlp_ignored", next_seq, 4);
      send_dllp(1'b1, 12'd1);
      check("replay_nak_ignored", {acknak_o, dllp_err}, 0);
      check("replay_ntr_stable", num_to_rep, 39);
      pulse_replay_done();
      check("replay_done_busy", replay_busy, 0);

      send_dllp(1'b0, 12'd1);
      check("ack_pre_to", acknak_o, 2'b01);
      for (int k = 1; k <= 4; k++) begin
         wait_timeout(seen);
         check($sformatf("to%0d_seen", k), seen, 1);
         check($sformatf("to%0d_num_to_rep", k), num_to_rep, 19);
         check($sformatf("to%0d_rollover", k), rollover_o, (k == 4) ? 1 : 0);
         check($sformatf("to%0d_busy", k), replay_busy, 1);
         pulse_replay_done();
      end

      do_reset();
      seq = 0;
      while (seq < 4095) begin
         int n;
         n = (4095 - seq > 500) ? 500 : 4095 - seq;
         send_tlps(n);
         seq += n;
         send_dllp(1'b0, 12'(seq - 1));
      end
      check("wrap_pre_next", next_seq, 4095);
      check("wrap_pre_ackd", ackd_seq, 4094);
      send_tlps(1);
      check("wrap_next_seq", next_seq, 0);
      send_dllp(1'b0, 12'd4095);
      check("wrap_ack_acknak", acknak_o, 2'b01);
      check("wrap_ack_ackd", ackd_seq, 4095);
      send_dllp(1'b0, 12'd5);
      check("oow_err", dllp_err, 1);
      check("oow_acknak", acknak_o, 0);
      check("oow_ackd", ackd_seq, 4095);
      step();
      check("oow_err_pulse_end", dllp_err, 0);
      send_dllp(1'b1, 12'd4095);
      check("nak_empty_acknak", acknak_o, 2'b10);
      check("nak_empty_ntr", num_to_rep, 0);
      check("nak_empty_busy", replay_busy, 0);

      do_reset();
      send_tlps(2);
      tlp_sent = 1'b1;
      send_dllp(1'b1, 12'd4095);
      tlp_sent = 1'b0;
      check("simul_acknak", acknak_o, 2'b10);
      check("simul_ntr", num_to_rep, 29);
      check("simul_next_seq", next_seq, 3);
      check("simul_busy", replay_busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_next_seq", next_seq, 0);
      check("async_ackd_seq", ackd_seq, 12'hFFF);
      check("async_acknak", acknak_o, 0);
      check("async_ntr", num_to_rep, 0);
      check("async_busy", replay_busy, 0);
      step();
      reset_n = 1'b1;
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
